// File: rtl/rgbled_pkg.sv
// Shared types and default 50 MHz timing for the streaming WS2812-style LED driver.
package rgbled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    WAIT,
    LATCH
  } state_t;

  localparam int CH_BITS = 8;

  localparam int DEF_T0H    = 20;
  localparam int DEF_T1H    = 40;
  localparam int DEF_TBIT   = 62;
  localparam int DEF_TLATCH = 2800;
  localparam int DEF_TGAP   = 1000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rgbled_stream_driver_if.sv
// Valid/ready word stream feeding the LED driver; master is the word source.
interface rgbled_stream_driver_if #(
  parameter int BITS_PER_LED = 24
);
  logic [BITS_PER_LED-1:0] data_in;
  logic                    data_valid;
  logic                    data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/rgbled_scale.sv
// Combinational per-channel brightness scaling: c' = (c * (brightness + 1)) >> 8.
module rgbled_scale
  import rgbled_pkg::*;
#(
  parameter int CHANNELS = 3
) (
  input  logic [CHANNELS*CH_BITS-1:0] word_in,
  input  logic [7:0]                  brightness,
  output logic [CHANNELS*CH_BITS-1:0] word_out
);

  logic [8:0] gain;
  assign gain = {1'b0, brightness} + 9'd1;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // 255 * 256 still fits in 16 bits, so the top byte is the scaled channel.
    logic [15:0] prod;
    assign prod = 16'(word_in[i*CH_BITS +: CH_BITS]) * 16'(gain);
    assign word_out[i*CH_BITS +: CH_BITS] = prod[15:8];
  end

endmodule

// File: rtl/rgbled_stream_driver.sv
// Streams LED words MSB-first as WS2812-style NRZ pulses with cycle-count timing.
// Define RGBLED_BRIGHTNESS_EN to scale every channel by the brightness input at load.
module rgbled_stream_driver
  import rgbled_pkg::*;
#(
  parameter int LEDS         = 8,
  parameter int BITS_PER_LED = 24,
  parameter int T0H          = DEF_T0H,
  parameter int T1H          = DEF_T1H,
  parameter int TBIT         = DEF_TBIT,
  parameter int TLATCH       = DEF_TLATCH,
  parameter int TGAP         = DEF_TGAP
) (
  input  logic                   clk,
  input  logic                   nreset,
  rgbled_stream_driver_if.slave  strm,
  input  logic [7:0]             brightness,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun,
  output logic                   led
);

  localparam int CNT_W = $clog2(max3(TBIT, TLATCH, TGAP) + 1);
  localparam int WC_W  = $clog2(LEDS + 1);
  localparam int BI_W  = $clog2(BITS_PER_LED);

  state_t                  state, state_nxt;
  logic [BITS_PER_LED-1:0] hold_q, shift_q, load_word;
  logic                    hold_full;
  logic [BI_W-1:0]         bit_idx;
  logic [CNT_W-1:0]        cnt;
  logic [WC_W-1:0]         word_cnt;
  logic                    aborted;
  logic                    accept;
  logic                    done_set, underrun_set;
  logic [CNT_W-1:0]        high_last;

  assign accept          = strm.data_valid && strm.data_ready;
  assign strm.data_ready = !hold_full;
  assign busy            = (state != IDLE);

`ifdef RGBLED_BRIGHTNESS_EN
  rgbled_scale #(
    .CHANNELS(BITS_PER_LED / CH_BITS)
  ) u_scale (
    .word_in   (hold_q),
    .brightness(brightness),
    .word_out  (load_word)
  );
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign load_word         = hold_q;
`endif

  // Last counter value of the high phase for the bit currently at the MSB.
  assign high_last = shift_q[BITS_PER_LED-1] ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned and a latch cannot be inferred.
  always_comb begin
    state_nxt    = state;
    done_set     = 1'b0;
    underrun_set = 1'b0;
    unique case (state)
      IDLE:  if (hold_full || accept) state_nxt = LOAD;
      LOAD:  state_nxt = HIGH;
      HIGH:  if (cnt == high_last) state_nxt = LOW;
      LOW: begin
        if (cnt == CNT_W'(TBIT - 1)) begin
          if (bit_idx != '0)                state_nxt = HIGH;
          else if (word_cnt == WC_W'(LEDS)) state_nxt = LATCH;
          else if (hold_full)               state_nxt = LOAD;
          else                              state_nxt = WAIT;
        end
      end
      // A word landing in the hold on the final gap cycle is too late; it waits for the next frame.
      WAIT: begin
        if (hold_full) begin
          state_nxt = LOAD;
        end else if (cnt == CNT_W'(TGAP - 1)) begin
          state_nxt    = LATCH;
          underrun_set = 1'b1;
        end
      end
      LATCH: begin
        if (cnt == CNT_W'(TLATCH - 1)) begin
          state_nxt = IDLE;
          done_set  = !aborted;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: the data registers are reset too, so a mid-frame reset leaves no stale word behind.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hold_q     <= '0;
      hold_full  <= 1'b0;
      shift_q    <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      word_cnt   <= '0;
      aborted    <= 1'b0;
      led        <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (accept) begin
        hold_q    <= strm.data_in;
        hold_full <= 1'b1;
      end else if (state == LOAD) begin
        hold_full <= 1'b0;
      end

      if (state == LOAD) begin
        shift_q  <= load_word;
        bit_idx  <= BI_W'(BITS_PER_LED - 1);
        word_cnt <= word_cnt + 1'b1;
      end else if (state == LOW && state_nxt == HIGH) begin
        shift_q <= shift_q << 1;
        bit_idx <= bit_idx - 1'b1;
      end else if (state == IDLE) begin
        word_cnt <= '0;
      end

      // The bit counter spans HIGH and LOW so LOW ends exactly TBIT cycles into the bit.
      if (state == IDLE || state == LOAD)               cnt <= '0;
      else if (state_nxt != state && state != HIGH)     cnt <= '0;
      else                                              cnt <= cnt + 1'b1;

      if (underrun_set)        aborted <= 1'b1;
      else if (state == IDLE)  aborted <= 1'b0;

      led        <= (state_nxt == HIGH);
      frame_done <= done_set;
      underrun   <= underrun_set;
    end
  end

endmodule

// File: tb/tb_rgbled_stream_driver.sv
// Scoreboard bench: words and frame events are queued at stimulus time and checked by a led decoder.
module tb_rgbled_stream_driver;
  import rgbled_pkg::*;

  localparam int LEDS   = 2;
  localparam int BITS   = 24;
  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int TBIT   = 6;
  localparam int TLATCH = 20;
  localparam int TGAP   = 10;

`ifdef RGBLED_BRIGHTNESS_EN
  localparam bit BRIGHT_EN = 1'b1;
`else
  localparam bit BRIGHT_EN = 1'b0;
`endif

  typedef enum logic {EV_DONE, EV_UNDERRUN} ev_t;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] brightness = 8'd255;
  logic       busy, frame_done, underrun, led;

  rgbled_stream_driver_if #(.BITS_PER_LED(BITS)) strm ();

  rgbled_stream_driver #(
    .LEDS(LEDS), .BITS_PER_LED(BITS), .T0H(T0H), .T1H(T1H),
    .TBIT(TBIT), .TLATCH(TLATCH), .TGAP(TGAP)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .strm      (strm),
    .brightness(brightness),
    .busy      (busy),
    .frame_done(frame_done),
    .underrun  (underrun),
    .led       (led)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BITS-1:0] exp_words[$];
  ev_t             exp_ev[$];
  int rise_count = 0;
  int done_count = 0;
  int ur_count   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference: each 8-bit channel becomes floor(c * (b + 1) / 256) when scaling is built in.
  function automatic logic [BITS-1:0] model_word(input logic [BITS-1:0] w, input logic [7:0] b);
    logic [BITS-1:0] r;
    int c;
    if (!BRIGHT_EN) return w;
    r = '0;
    for (int ch = 0; ch < BITS / 8; ch++) begin
      c = int'(w[ch*8 +: 8]);
      c = (c * (int'(b) + 1)) / 256;
      r[ch*8 +: 8] = c[7:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [BITS-1:0] w);
    int t;
    t = 0;
    strm.data_in    = w;
    strm.data_valid = 1'b1;
    while (!strm.data_ready && t < 2000) begin
      tick();
      t++;
    end
    check("send_ready", strm.data_ready, 1'b1);
    exp_words.push_back(model_word(w, brightness));
    tick();
    strm.data_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_count < target && t < 3000) begin
      tick();
      t++;
    end
    check("wait_frame_done", done_count >= target, 1'b1);
  endtask

  task automatic wait_ur(input int target);
    int t;
    t = 0;
    while (ur_count < target && t < 3000) begin
      tick();
      t++;
    end
    check("wait_underrun", ur_count >= target, 1'b1);
  endtask

  task automatic wait_rises(input int target);
    int t;
    t = 0;
    while (rise_count < target && t < 3000) begin
      tick();
      t++;
    end
    check("wait_led_rise", rise_count >= target, 1'b1);
  endtask

  // Monitor: decodes pulses into words and checks frame events against the queues.
  initial begin
    int high_cnt, low_cnt, last_high, nbits;
    logic [BITS-1:0] acc_word;
    ev_t ev;
    high_cnt = 0; low_cnt = 0; last_high = 0; nbits = 0; acc_word = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        high_cnt = 0;
        low_cnt  = 0;
        nbits    = 0;
        exp_words.delete();
        exp_ev.delete();
      end else begin
        if (led) begin
          if (high_cnt == 0) rise_count++;
          high_cnt++;
        end else if (high_cnt != 0) begin
          check("pulse_width_legal", (high_cnt == T0H) || (high_cnt == T1H), 1'b1);
          acc_word  = {acc_word[BITS-2:0], (high_cnt == T1H)};
          nbits++;
          last_high = high_cnt;
          high_cnt  = 0;
          low_cnt   = 0;
          if (nbits == BITS) begin
            nbits = 0;
            check("word_expected", exp_words.size() > 0, 1'b1);
            if (exp_words.size() > 0) check("led_word", acc_word, exp_words.pop_front());
          end
        end
        if (frame_done || underrun) begin
          check("done_underrun_exclusive", frame_done && underrun, 1'b0);
          check("event_expected", exp_ev.size() > 0, 1'b1);
          if (exp_ev.size() > 0) begin
            ev = exp_ev.pop_front();
            check("event_kind", underrun ? EV_UNDERRUN : EV_DONE, ev);
          end
          if (frame_done) begin
            done_count++;
            check("latch_low_cycles", low_cnt, TBIT - last_high + TLATCH);
            check("busy_at_done", busy, 1'b0);
          end else begin
            ur_count++;
            check("gap_low_cycles", low_cnt, TBIT - last_high + TGAP);
          end
        end
        if (led) low_cnt = 0;
        else     low_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, u0, r0, n, acc;
    strm.data_in    = '0;
    strm.data_valid = 1'b0;
    nreset          = 1'b0;
    repeat (3) tick();
    check("rst_led", led, 1'b0);
    check("rst_ready", strm.data_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    nreset = 1'b1;
    tick();

    // Reset while led is high and the hold register is full.
    send(24'hA5A5A5);
    send(24'h5A5A5A);
    check("pre_reset_led_high", led, 1'b1);
    check("pre_reset_hold_full", strm.data_ready, 1'b0);
    nreset = 1'b0;
    #1;
    check("mid_reset_led", led, 1'b0);
    check("mid_reset_ready", strm.data_ready, 1'b1);
    check("mid_reset_busy", busy, 1'b0);
    repeat (2) tick();
    nreset = 1'b1;
    tick();
    check("post_reset_state", 64'(dut.state), 64'(IDLE));
    check("post_reset_led", led, 1'b0);

    // Back-to-back frame with first-bit latency.
    brightness = 8'd255;
    d0 = done_count;
    exp_ev.push_back(EV_DONE);
    send(24'hFF0000);
    check("load_cycle_led_low", led, 1'b0);
    check("load_cycle_busy", busy, 1'b1);
    tick();
    check("led_rise_latency", led, 1'b1);
    send(24'h000001);
    wait_done(d0 + 1);

    // Single word: gap expires, underrun, latch, no frame_done.
    d0 = done_count;
    u0 = ur_count;
    exp_ev.push_back(EV_UNDERRUN);
    send(24'($urandom));
    wait_ur(u0 + 1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("underrun_latch_cycles", n, TLATCH);
    repeat (5) tick();
    check("no_done_after_underrun", done_count, d0);

    // Second word accepted on the 9th gap cycle keeps the frame alive.
    d0 = done_count;
    u0 = ur_count;
    exp_ev.push_back(EV_DONE);
    r0 = rise_count;
    send(24'($urandom));
    wait_rises(r0 + BITS);
    repeat (TBIT + 8) tick();
    send(24'($urandom));
    wait_done(d0 + 1);
    check("no_underrun_gap9", ur_count, u0);

    // Word accepted on the final gap cycle: underrun wins, word starts the next frame.
    d0 = done_count;
    u0 = ur_count;
    exp_ev.push_back(EV_UNDERRUN);
    exp_ev.push_back(EV_DONE);
    r0 = rise_count;
    send(24'($urandom));
    wait_rises(r0 + BITS);
    repeat (TBIT + 9) tick();
    send(24'($urandom));
    check("held_over_underrun", strm.data_ready, 1'b0);
    send(24'($urandom));
    wait_ur(u0 + 1);
    wait_done(d0 + 1);

    // Brightness scaling.
    brightness = 8'd127;
    d0 = done_count;
    exp_ev.push_back(EV_DONE);
    send(24'hFF8001);
    send(24'($urandom));
    wait_done(d0 + 1);
    brightness = 8'd255;

    // data_valid held through LATCH: one word accepted, next frame right after IDLE.
    d0 = done_count;
    exp_ev.push_back(EV_DONE);
    exp_ev.push_back(EV_DONE);
    r0 = rise_count;
    send(24'($urandom));
    send(24'($urandom));
    wait_rises(r0 + 2 * BITS);
    repeat (TBIT) tick();
    strm.data_in    = 24'($urandom);
    strm.data_valid = 1'b1;
    acc = 0;
    n   = 0;
    while (done_count == d0 && n < TLATCH + 10) begin
      if (strm.data_ready) begin
        acc++;
        exp_words.push_back(model_word(strm.data_in, brightness));
      end
      tick();
      n++;
    end
    check("latch_single_accept", acc, 1);
    check("idle_ready_low", strm.data_ready, 1'b0);
    check("idle_busy_low", busy, 1'b0);
    strm.data_valid = 1'b0;
    tick();
    check("load_after_idle_busy", busy, 1'b1);
    check("load_after_idle_led", led, 1'b0);
    tick();
    check("next_frame_start", led, 1'b1);
    send(24'($urandom));
    wait_done(d0 + 2);

    // Randomised complete frames.
    for (int f = 0; f < 6; f++) begin
      d0 = done_count;
      brightness = 8'($urandom);
      exp_ev.push_back(EV_DONE);
      for (int i = 0; i < LEDS; i++) begin
        repeat ($urandom_range(0, 4)) tick();
        send(24'($urandom));
      end
      wait_done(d0 + 1);
    end

    repeat (5) tick();
    check("words_drained", exp_words.size(), 0);
    check("events_drained", exp_ev.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgbled_stream_driver.md
# rgbled_stream_driver

Parametrised successor to the single-string WS2812 LED driver. It accepts LED words over a valid/ready stream instead of a full-width frame register, and serialises them MSB-first as WS2812-style NRZ pulses on `led`. Bit timing is set by cycle-count parameters, so any clock frequency works. It supports 24- or 32-bit LEDs (RGB/RGBW), optional global brightness scaling, and underrun detection. It sits between the SPI receiver (or a frame buffer) and the LED pin in the top-level wrapper.

## Interface
Parameters:
- `LEDS`, 8: LED words per frame (≥1)
- `BITS_PER_LED`, 24: bits per word; must be 24 or 32
- `T0H`, 20: high cycles for a 0 bit (0.4 µs at 50 MHz)
- `T1H`, 40: high cycles for a 1 bit
- `TBIT`, 62: total cycles per bit; require `T0H < T1H < TBIT`
- `TLATCH`, 2800: low cycles for the latch/reset gap (56 µs at 50 MHz)
- `TGAP`, 1000: maximum low wait between words before an underrun

Ports:
- `clk`  in  1: clock; the only clock
- `nreset`  in  1: asynchronous, active-low reset
- `data_in`  in  `BITS_PER_LED`: LED word, already in wire order (e.g. GRB), MSB sent first
- `data_valid`  in  1: `data_in` is valid
- `data_ready`  out  1: holding register is empty
- `brightness`  in  8: global brightness; only used with `RGBLED_BRIGHTNESS_EN`
- `busy`  out  1: state ≠ IDLE
- `frame_done`  out  1: one-cycle pulse when a complete frame has latched
- `underrun`  out  1: one-cycle pulse when a frame is aborted
- `led`  out  1: serial LED data line

## Operation
- Storage: one holding register plus one shift register. A word is accepted on a cycle where `data_valid & data_ready`. `data_ready = !hold_full`, in every state, including LATCH.
- States:
  - IDLE: `led`=0, word count=0. If `hold_full`, move to LOAD.
  - LOAD: one cycle. Hold → scale → shift register; hold becomes empty; bit index=`BITS_PER_LED-1`. Move to HIGH.
  - HIGH: `led`=1 for T1H cycles if the current bit is 1, else T0H. Then LOW.
  - LOW: `led`=0 until the bit cycle counter reaches TBIT.
    - More bits in the word: shift and go to HIGH.
    - Last bit and word count < `LEDS`: if `hold_full`, go to LOAD; else WAIT.
    - Last bit and word count == `LEDS`: go to LATCH.
  - WAIT: `led`=0, gap counter runs. A word arriving (`hold_full`) moves to LOAD. If the gap counter reaches TGAP first: pulse `underrun`, go to LATCH; that frame gets no `frame_done`.
  - LATCH: `led`=0 for TLATCH cycles. Then pulse `frame_done` (complete frames only) and go to IDLE.
- Word count increments at each LOAD.
- Counter widths: `$clog2(max(TBIT,TLATCH,TGAP)+1)`. Word count width: `$clog2(LEDS+1)`.
- Reset mid-operation: `led`, `busy`, `frame_done` and `underrun` go to 0 and `data_ready` to 1 immediately. The holding register is cleared and all counters reset.

## Timing
- Reset values: `led`=0, `data_ready`=1, `busy`=0, `frame_done`=0, `underrun`=0.
- All outputs are registered except `data_ready` and `busy`, which decode registered state.
- Latency: word accepted in cycle n → hold_full in n+1 → LOAD in n+1 → `led` rises in n+2.
- Back-to-back words: LOAD adds exactly one low cycle to the last bit of the previous word. That bit's period is TBIT+1, which WS2812 tolerates.
- Simultaneous events:
  - Accept and LOAD in the same cycle: LOAD consumes the old hold contents; the new word is captured.
  - A word arriving on the cycle WAIT expires: the underrun wins. The word stays held for the next frame.
- `frame_done` and `underrun` are never asserted in the same cycle.

## Configuration
- `RGBLED_BRIGHTNESS_EN` defined: at LOAD, each 8-bit channel c becomes `(c*(brightness+1))>>8`. 255 gives identity; 0 gives 0 for every channel.
- Not defined: the `brightness` port exists but is ignored; words pass unchanged; no multipliers are synthesised.

## Structure
- Package `rgbled_pkg`:
  - state enum (IDLE, LOAD, HIGH, LOW, WAIT, LATCH)
  - default timing constants for 50 MHz
  - `CH_BITS = 8`
- Sub-module `rgbled_scale`: combinational per-channel brightness multiplier over `BITS_PER_LED/8` channels. It is instantiated only under `RGBLED_BRIGHTNESS_EN`.

## Test plan
Bench parameters: `LEDS`=2, T0H=2, T1H=4, TBIT=6, TLATCH=20, TGAP=10.
- Reset with `led` mid-HIGH → `led`=0 and `data_ready`=1 in the same cycle; after release, state IDLE.
- Send 0xFF0000, then 0x000001 back-to-back → 48 pulses:
  - first 8 pulses high 4 cycles, next 39 high 2 cycles, last high 4 cycles
  - then 20 low cycles, then one `frame_done` pulse, `busy`=0
- Send one word only → after 24 bits, `led` low 10 cycles, `underrun` pulse, 20 LATCH cycles, no `frame_done`.
- Word 2 arrives at gap cycle 9 → frame continues, `frame_done` asserted, no `underrun`.
- With `RGBLED_BRIGHTNESS_EN`, `brightness`=127, word 0xFF8001 → transmitted bits are 0x7F4000.
- Keep `data_valid` high during LATCH → exactly one word accepted, `data_ready`=0 until IDLE→LOAD; the next frame starts one cycle after IDLE.
